// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time,
// byte/half/word access on a little-endian word array with programmable wait states.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: the initiator raises req with stable we/addr/wdata/size/unsigned_ld
  // and holds it; a request is taken only in IDLE, and ready pulses for exactly one
  // cycle with rdata/err valid in that cycle. Both rdata and err are 0 otherwise.

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [3:0]  count;
  logic        armed;
  logic        lat_we, lat_unsigned;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_size;
  logic [31:0] resp_data;
  logic        resp_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        acc_we, acc_unsigned;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_size, lane;
  logic        in_range, misaligned, fault;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word, load_val, wr_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;

  // armed stays low for the first edge after reset so no access can complete while
  // reset is still settling (matters only when WAIT_STATES is 0).
  assign accept = (state == IDLE) && req && armed;

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  assign acc_we       = (state == IDLE) ? we          : lat_we;
  assign acc_addr     = (state == IDLE) ? addr        : lat_addr;
  assign acc_wdata    = (state == IDLE) ? wdata       : lat_wdata;
  assign acc_size     = (state == IDLE) ? size        : lat_size;
  assign acc_unsigned = (state == IDLE) ? unsigned_ld : lat_unsigned;

  assign lane     = acc_addr[1:0];
  assign idx      = IDX_W'((acc_addr - ADDR_BASE) >> 2);
  assign in_range = ({1'b0, acc_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, acc_addr} < LIMIT);
  assign rd_word  = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    case (acc_size)
      2'b01:   misaligned = acc_addr[0];
      2'b10:   misaligned = |acc_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign fault      = (acc_size == 2'b11) || misaligned || !in_range;
  assign enter_resp = (state != RESP) && (next_state == RESP);

  always_comb begin
    ld_byte  = rd_word[{lane, 3'b000} +: 8];
    ld_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (acc_size)
      2'b00:   load_val = {{24{~acc_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~acc_unsigned & ld_half[15]}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    be      = 4'b0000;
    wr_word = acc_wdata;
    case (acc_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_word = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be      = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        wr_word = acc_wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      armed        <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      resp_data    <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (accept) begin
        count        <= WAIT_STATES[3:0];
        lat_we       <= we;
        lat_addr     <= addr;
        lat_wdata    <= wdata;
        lat_size     <= size;
        lat_unsigned <= unsigned_ld;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (enter_resp) begin
        resp_err  <= fault;
        resp_data <= (fault || acc_we) ? 32'd0 : load_val;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (count <= 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == RESP);
    rdata     = (state == RESP) ? resp_data : 32'd0;
    err       = (state == RESP) ? resp_err : 1'b0;
    state_dbg = state;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 1, 0 and 3 wait states
// driven from shared data inputs and individual req lines.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  req;
  logic        we;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [2:0]  ready, err;
  logic [31:0] rdata [3];
  logic [1:0]  state_dbg [3];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lat [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .ADDR_BASE(32'h0)) u_ws1 (
    .clk(clk), .n_reset(n_reset), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .unsigned_ld(unsigned_ld), .ready(ready[0]), .rdata(rdata[0]),
    .err(err[0]), .state_dbg(state_dbg[0]));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0)) u_ws0 (
    .clk(clk), .n_reset(n_reset), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .unsigned_ld(unsigned_ld), .ready(ready[1]), .rdata(rdata[1]),
    .err(err[1]), .state_dbg(state_dbg[1]));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_BASE(32'h0)) u_ws3 (
    .clk(clk), .n_reset(n_reset), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .unsigned_ld(unsigned_ld), .ready(ready[2]), .rdata(rdata[2]),
    .err(err[2]), .state_dbg(state_dbg[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_access(input int sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic u,
                           output logic [31:0] rd, output logic e, output int lat);
    logic seen;
    @(negedge clk);
    we = w; addr = a; wdata = d; size = sz; unsigned_ld = u;
    req[sel] = 1'b1;
    seen = 1'b0; lat = 0; rd = 32'hx; e = 1'bx;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (ready[sel]) begin
        seen = 1'b1; lat = c; rd = rdata[sel]; e = err[sel];
      end
    end
    req[sel] = 1'b0;
    check("ready_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("ready_one_cycle", {31'd0, ready[sel]}, 32'd0);
    check("rdata_zero_after", rdata[sel], 32'd0);
  endtask

  task automatic txn(input string tag, input int sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input logic u,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    do_access(sel, w, a, d, sz, u, rd, e, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_latency"}, lat, exp_lat[sel]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] pattern;
    int         pulses;

    n_reset = 1'b0; req = 3'b000; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    size = 2'b10; unsigned_ld = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", {31'd0, ready[i]}, 32'd0);
      check("reset_rdata", rdata[i], 32'd0);
      check("reset_err", {31'd0, err[i]}, 32'd0);
      check("reset_state", {30'd0, state_dbg[i]}, 32'd0);
    end
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Word store and load round trip.
    txn("sw_10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    txn("lw_10", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // Sub-word stores, sign and zero extension.
    txn("sb_11", 0, 1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0);
    txn("lb_11", 0, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    txn("lbu_11", 0, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    txn("lw_10b", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0);
    txn("sh_12", 0, 1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b0);
    txn("lw_10c", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h123480EF, 1'b0);
    txn("lh_10", 0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'hFFFF80EF, 1'b0);
    txn("lhu_10", 0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h000080EF, 1'b0);
    txn("lb_13", 0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'h00000012, 1'b0);

    // Alignment and size faults; faulting store must not write.
    txn("lw_12_mis", 0, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    txn("sh_13_mis", 0, 1'b1, 32'h13, 32'hFFFF, 2'b01, 1'b0, 32'h0, 1'b1);
    txn("size3", 0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    txn("lw_10d", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h123480EF, 1'b0);

    // Top of the array and just beyond it.
    txn("sw_top", 0, 1'b1, 32'h3FC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0);
    txn("lw_top", 0, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
    txn("lbu_3ff", 0, 1'b0, 32'h3FF, 32'h0, 2'b00, 1'b1, 32'h000000CA, 1'b0);
    txn("lw_400", 0, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    txn("sw_400", 0, 1'b1, 32'h400, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b1);
    txn("lw_wrap", 0, 1'b0, 32'hFFFFFFFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);

    // Zero and three wait states.
    txn("ws0_sw", 1, 1'b1, 32'h40, 32'h01020304, 2'b10, 1'b0, 32'h0, 1'b0);
    txn("ws0_lw", 1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0);
    txn("ws3_sw", 2, 1'b1, 32'h44, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0);
    txn("ws3_lw", 2, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0);

    // req held high: ready pattern per negedge, bit k = k-th cycle after raising req.
    @(negedge clk);
    we = 1'b0; addr = 32'h40; size = 2'b10; unsigned_ld = 1'b0; req[1] = 1'b1;
    pattern = 9'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pattern[k] = ready[1];
    end
    req[1] = 1'b0;
    check("b2b_ws0_pattern", {23'd0, pattern}, 32'h015);
    repeat (3) @(negedge clk);

    addr = 32'h44; req[2] = 1'b1;
    pattern = 9'd0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      pattern[k] = ready[2];
    end
    req[2] = 1'b0;
    check("b2b_ws3_pattern", {23'd0, pattern}, 32'h108);
    repeat (3) @(negedge clk);

    // Reset during WAIT aborts the store.
    txn("ws3_sw_20", 2, 1'b1, 32'h20, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h55AA55AA; size = 2'b10; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    check("abort_in_wait", {30'd0, state_dbg[2]}, 32'd1);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("abort_state", {30'd0, state_dbg[2]}, 32'd0);
    check("abort_rdata", rdata[2], 32'd0);
    pulses = 0;
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready[2]) pulses++;
    end
    check("abort_no_ready", pulses, 32'd0);
    check("abort_err", {31'd0, err[2]}, 32'd0);
    txn("ws3_lw_20", 2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
